// File: rtl/i2s_pkg.sv
// Shared I2S definitions: transmitter state encoding, default frame geometry
// (also used by the clock stage), and the bit-counter width helper.
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LEFT,
    RIGHT
  } i2s_state_e;

  localparam int unsigned I2S_DATA_WIDTH = 24;
  localparam int unsigned I2S_SLOT_WIDTH = 32;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) width = i + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/i2s_edge_det.sv
// Single-register edge detector for clocks generated in the mclk_in domain.
module i2s_edge_det (
  input  logic mclk_in,
  input  logic arstn_in,
  input  logic sig_in,
  output logic rise_out,
  output logic fall_out,
  output logic any_out
);

  logic prev_q;
  logic prev_d;

  always_comb prev_d = sig_in;

  always_ff @(posedge mclk_in or negedge arstn_in) begin
    if (!arstn_in) prev_q <= 1'b0;
    else           prev_q <= prev_d;
  end

  assign rise_out = ~prev_q & sig_in;
  assign fall_out = prev_q & ~sig_in;
  assign any_out  = prev_q ^ sig_in;

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: one-deep holding register, per-frame load on lrck fall,
// MSB-first output with 1-bit delay. Option: I2S_TX_REPEAT_ON_UNDERRUN_EN.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = I2S_DATA_WIDTH,
  parameter int unsigned SLOT_WIDTH = I2S_SLOT_WIDTH
) (
  input  logic                  arstn_in,
  input  logic                  mclk_in,
  input  logic                  lrck_in,
  input  logic                  sclk_in,
  input  logic [DATA_WIDTH-1:0] left_in,
  input  logic [DATA_WIDTH-1:0] right_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic                  sdata_out,
  output logic                  underrun_out
);

  localparam int unsigned CNT_W = clog2(SLOT_WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SLOT_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_WIDTH);

  logic lrck_rise, lrck_fall, lrck_any;
  logic sclk_rise, sclk_fall, sclk_any;
  logic unused_edges;

  i2s_edge_det u_lrck_det (
    .mclk_in (mclk_in),
    .arstn_in(arstn_in),
    .sig_in  (lrck_in),
    .rise_out(lrck_rise),
    .fall_out(lrck_fall),
    .any_out (lrck_any)
  );

  i2s_edge_det u_sclk_det (
    .mclk_in (mclk_in),
    .arstn_in(arstn_in),
    .sig_in  (sclk_in),
    .rise_out(sclk_rise),
    .fall_out(sclk_fall),
    .any_out (sclk_any)
  );

  assign unused_edges = sclk_rise | sclk_any;

  i2s_state_e            state_q, state_d;
  logic                  hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [DATA_WIDTH-1:0] shift_l_q, shift_l_d, shift_r_q, shift_r_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  sdata_q, sdata_d;
  logic                  ready_q, ready_d;
  logic                  underrun_q, underrun_d;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
  logic [DATA_WIDTH-1:0] last_l_q, last_l_d, last_r_q, last_r_d;
`endif

  always_comb begin
    state_d     = state_q;
    hold_full_d = hold_full_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    shift_l_d   = shift_l_q;
    shift_r_d   = shift_r_q;
    bit_cnt_d   = bit_cnt_q;
    sdata_d     = sdata_q;
    underrun_d  = 1'b0;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
    last_l_d    = last_l_q;
    last_r_d    = last_r_q;
`endif

    // Frame load precedes the handshake so a same-cycle transfer lands in
    // the now-empty holding register for the following frame.
    if (lrck_fall) begin
      if (hold_full_q) begin
        shift_l_d   = hold_l_q;
        shift_r_d   = hold_r_q;
        hold_full_d = 1'b0;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
        last_l_d    = hold_l_q;
        last_r_d    = hold_r_q;
`endif
      end else begin
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
        shift_l_d = last_l_q;
        shift_r_d = last_r_q;
`else
        shift_l_d = '0;
        shift_r_d = '0;
`endif
        underrun_d = 1'b1;
      end
    end

    if (valid_in && ready_q) begin
      hold_l_d    = left_in;
      hold_r_d    = right_in;
      hold_full_d = 1'b1;
    end
    ready_d = ~hold_full_d;

    case (state_q)
      IDLE:    if (lrck_fall) state_d = LEFT;
      LEFT:    if (lrck_rise) state_d = RIGHT;
      RIGHT:   if (lrck_fall) state_d = LEFT;
      default: state_d = IDLE;
    endcase

    if (lrck_any) begin
      bit_cnt_d = '0;
    end else if (sclk_fall && (state_q != IDLE) && (bit_cnt_q != CNT_MAX)) begin
      bit_cnt_d = bit_cnt_q + 1'b1;
    end

    // bit_cnt_d is the slot position k of the bit presented on this sclk fall
    if (state_q == IDLE) begin
      sdata_d = 1'b0;
    end else if (sclk_fall) begin
      if ((bit_cnt_d != '0) && (bit_cnt_d <= CNT_DATA) && !lrck_any) begin
        if (state_q == LEFT) begin
          sdata_d   = shift_l_q[DATA_WIDTH-1];
          shift_l_d = shift_l_q << 1;
        end else begin
          sdata_d   = shift_r_q[DATA_WIDTH-1];
          shift_r_d = shift_r_q << 1;
        end
      end else begin
        sdata_d = 1'b0;
      end
    end
  end

  always_ff @(posedge mclk_in or negedge arstn_in) begin
    if (!arstn_in) begin
      state_q     <= IDLE;
      hold_full_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      shift_l_q   <= '0;
      shift_r_q   <= '0;
      bit_cnt_q   <= '0;
      sdata_q     <= 1'b0;
      ready_q     <= 1'b1;
      underrun_q  <= 1'b0;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
      last_l_q    <= '0;
      last_r_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      shift_l_q   <= shift_l_d;
      shift_r_q   <= shift_r_d;
      bit_cnt_q   <= bit_cnt_d;
      sdata_q     <= sdata_d;
      ready_q     <= ready_d;
      underrun_q  <= underrun_d;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
      last_l_q    <= last_l_d;
      last_r_q    <= last_r_d;
`endif
    end
  end

  assign ready_out    = ready_q;
  assign sdata_out    = sdata_q;
  assign underrun_out = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: frame table + random frames against a
// slot-level model, plus back-to-back handshake and mid-frame reset sequences.
module tb_i2s_tx;

  localparam int DW = 24;

`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic          mclk = 1'b0;
  logic          arstn = 1'b0;
  logic [7:0]    c = 8'd0;
  logic          lrck, sclk;
  logic [DW-1:0] left = '0, right = '0;
  logic          valid = 1'b0;
  logic          ready_out, sdata_out, underrun_out;

  int checks = 0;
  int failures = 0;
  int under_cnt = 0;

  // Clock stage: MCLK_DIV_SCLK=4, MCLK_DIV_LRCK=256; lrck edges fall on sclk falls.
  assign sclk = c[1];
  assign lrck = c[7];

  always #5 mclk = ~mclk;
  always @(posedge mclk) begin
    #2;
    c = c + 8'd1;
  end

  i2s_tx #(.DATA_WIDTH(24), .SLOT_WIDTH(32)) dut (
    .arstn_in    (arstn),
    .mclk_in     (mclk),
    .lrck_in     (lrck),
    .sclk_in     (sclk),
    .left_in     (left),
    .right_in    (right),
    .valid_in    (valid),
    .ready_out   (ready_out),
    .sdata_out   (sdata_out),
    .underrun_out(underrun_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Underrun pulses must appear only in the cycle after the frame-start detection.
  always @(negedge mclk) begin
    if (arstn && underrun_out) begin
      under_cnt++;
      check("underrun_timing", 32'(c), 32'd1);
    end
  end

  function automatic logic [31:0] slot_word(input logic [DW-1:0] s);
    return {1'b0, s, 7'b0};
  endfunction

  task automatic wait_c(input logic [7:0] v);
    for (int i = 0; i < 600; i++) begin
      @(negedge mclk);
      if (c == v) return;
    end
    check("wait_c_timeout", 32'(c), 32'(v));
  endtask

  task automatic capture(output logic [31:0] ls, output logic [31:0] rs);
    ls = '0;
    rs = '0;
    for (int j = 0; j < 64; j++) begin
      @(posedge sclk);
      if (j < 32) ls = {ls[30:0], sdata_out};
      else        rs = {rs[30:0], sdata_out};
    end
  endtask

  task automatic push(input logic [DW-1:0] l, input logic [DW-1:0] r);
    check("ready_before_push", 32'(ready_out), 32'd1);
    left  = l;
    right = r;
    valid = 1'b1;
    @(negedge mclk);
    valid = 1'b0;
    check("ready_after_push", 32'(ready_out), 32'd0);
  endtask

  typedef struct {
    logic          push;
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    logic [DW-1:0] exp_l;
    logic [DW-1:0] exp_r;
    logic          exp_under;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic p, input logic [DW-1:0] l, input logic [DW-1:0] r,
                              input logic [DW-1:0] el, input logic [DW-1:0] er, input logic eu);
    vec_t v;
    v.push = p; v.l = l; v.r = r; v.exp_l = el; v.exp_r = er; v.exp_under = eu;
    return v;
  endfunction

  initial begin
    logic [31:0]   ls, rs, ls2, rs2;
    logic [DW-1:0] ml, mr, rl, rr;
    logic          p, quiet;
    int            u0, n;

    repeat (3) @(negedge mclk);
    check("reset_sdata", 32'(sdata_out), 32'd0);
    check("reset_ready", 32'(ready_out), 32'd1);
    check("reset_underrun", 32'(underrun_out), 32'd0);
    arstn = 1'b1;

    vq.push_back(mk(1'b1, 24'hA5A5A5, 24'h5A5A5A, 24'hA5A5A5, 24'h5A5A5A, 1'b0));
    for (int i = 0; i < 3; i++)
      vq.push_back(mk(1'b0, '0, '0, REP ? 24'hA5A5A5 : 24'h0, REP ? 24'h5A5A5A : 24'h0, 1'b1));
    vq.push_back(mk(1'b1, 24'h800000, 24'h7FFFFF, 24'h800000, 24'h7FFFFF, 1'b0));
    vq.push_back(mk(1'b1, 24'h123456, 24'h654321, 24'h123456, 24'h654321, 1'b0));
    vq.push_back(mk(1'b0, '0, '0, REP ? 24'h123456 : 24'h0, REP ? 24'h654321 : 24'h0, 1'b1));

    // Random frames: model tracks the last pair actually loaded for transmission.
    ml = 24'h123456;
    mr = 24'h654321;
    for (int i = 0; i < 12; i++) begin
      p  = ($urandom_range(0, 3) != 0);
      rl = DW'($urandom);
      rr = DW'($urandom);
      if (p) begin
        vq.push_back(mk(1'b1, rl, rr, rl, rr, 1'b0));
        ml = rl;
        mr = rr;
      end else begin
        vq.push_back(mk(1'b0, rl, rr, REP ? ml : '0, REP ? mr : '0, 1'b1));
      end
    end

    n = vq.size();
    wait_c(8'd100);
    if (vq[0].push) push(vq[0].l, vq[0].r);
    for (int i = 0; i < n; i++) begin
      u0 = under_cnt;
      wait_c(8'd0);
      fork
        capture(ls, rs);
        begin
          wait_c(8'd100);
          if (i + 1 < n && vq[i+1].push) push(vq[i+1].l, vq[i+1].r);
        end
      join
      check($sformatf("frame%0d_left", i), ls, slot_word(vq[i].exp_l));
      check($sformatf("frame%0d_right", i), rs, slot_word(vq[i].exp_r));
      check($sformatf("frame%0d_underrun", i), 32'(under_cnt - u0), 32'(vq[i].exp_under));
    end

    // Back-to-back pairs with valid held: P2 waits for the frame load to free the holding register.
    wait_c(8'd100);
    u0 = under_cnt;
    fork
      begin
        wait_c(8'd0);
        capture(ls, rs);
        wait_c(8'd0);
        capture(ls2, rs2);
      end
      begin
        left = 24'h111111; right = 24'h222222; valid = 1'b1;
        @(negedge mclk);
        check("b2b_ready_low", 32'(ready_out), 32'd0);
        left = 24'h333333; right = 24'h444444;
        for (int k = 0; k < 400 && !ready_out; k++) @(negedge mclk);
        check("b2b_ready_back", 32'(ready_out), 32'd1);
        check("b2b_ready_phase", 32'(c), 32'd1);
        @(negedge mclk);
        check("b2b_p2_accepted", 32'(ready_out), 32'd0);
        valid = 1'b0;
      end
    join
    check("b2b_p1_left", ls, slot_word(24'h111111));
    check("b2b_p1_right", rs, slot_word(24'h222222));
    check("b2b_p2_left", ls2, slot_word(24'h333333));
    check("b2b_p2_right", rs2, slot_word(24'h444444));
    check("b2b_underrun", 32'(under_cnt - u0), 32'd0);

    // Asynchronous reset in the middle of an all-ones right slot.
    wait_c(8'd100);
    push(24'h0F0F0F, 24'hFFFFFF);
    wait_c(8'd0);
    wait_c(8'd180);
    check("pre_reset_sdata", 32'(sdata_out), 32'd1);
    arstn = 1'b0;
    #1;
    check("async_reset_sdata", 32'(sdata_out), 32'd0);
    check("async_reset_ready", 32'(ready_out), 32'd1);
    @(negedge mclk);
    @(negedge mclk);
    arstn = 1'b1;
    wait_c(8'd200);
    push(24'hC3C3C3, 24'h3C3C3C);
    quiet = 1'b1;
    for (int k = 0; k < 300 && c != 8'd0; k++) begin
      if (sdata_out !== 1'b0) quiet = 1'b0;
      @(negedge mclk);
    end
    check("post_reset_quiet", 32'(quiet), 32'd1);
    u0 = under_cnt;
    capture(ls, rs);
    check("post_reset_left", ls, slot_word(24'hC3C3C3));
    check("post_reset_right", rs, slot_word(24'h3C3C3C));
    check("post_reset_underrun", 32'(under_cnt - u0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Serialises stereo PCM samples onto an I2S data line in the mclk_in domain.
- Consumes lrck/sclk from the I2S clock generator stage, which runs on the same mclk_in, so no synchroniser is needed.
- Accepts one left/right pair per frame through a valid/ready handshake from the DSP pipeline.
- Drives sdata_out to the DAC.

Parameters:
- DATA_WIDTH, 24, bits per sample (two's complement).
- SLOT_WIDTH, 32, sclk periods per channel slot. Must equal MCLK_DIV_LRCK/(2*MCLK_DIV_SCLK) of the clock stage. Legal range: DATA_WIDTH+1 <= SLOT_WIDTH <= 64.

Ports:
- arstn_in  in  1  reset, asynchronous, active-low.
- mclk_in  in  1  clock; all logic is on its rising edge.
- lrck_in  in  1  word clock from clock stage; 0 = left slot, 1 = right slot.
- sclk_in  in  1  bit clock from clock stage; period >= 4 mclk_in.
- left_in  in  DATA_WIDTH  left sample.
- right_in  in  DATA_WIDTH  right sample.
- valid_in  in  1  sample pair valid.
- ready_out  out  1  holding register empty.
- sdata_out  out  1  I2S serial data.
- underrun_out  out  1  one-cycle pulse when a frame starts with no pair available.

Behaviour:
- Reset values: sdata_out=0, ready_out=1, underrun_out=0, state=IDLE, holding empty, shift register 0, bit counter 0.
- Edge detection: lrck_in and sclk_in are registered once (prev).
  - lrck_fall = prev&~cur; lrck_edge = prev^cur; sclk_fall = prev&~cur.
  - All actions below occur on the mclk_in edge where the detection is true.
- Handshake:
  - A transfer occurs when valid_in&&ready_out; left_in/right_in are captured into the holding register.
  - ready_out = ~hold_full, registered. It deasserts the cycle after a transfer and reasserts the cycle after the holding register is loaded into the shift register.
- State machine:
  - IDLE -> LEFT on lrck_fall. No other exit.
  - LEFT -> RIGHT on lrck_edge with lrck rising.
  - RIGHT -> LEFT on lrck_fall.
  - In IDLE, sdata_out=0 and sclk edges are ignored. The handshake still operates.
- Frame load (on each lrck_fall, including the exit from IDLE):
  - If the holding register is full: copy it to shift registers {L,R} and mark the holding register empty.
  - If it is empty: load zeros and pulse underrun_out for 1 cycle.
  - Load and a handshake in the same cycle: the frame counts as an underrun. The new pair lands in the holding register for the next frame; there is no bypass.
- Bit timing (standard I2S, 1-bit delay):
  - Bit counter k resets to 0 on lrck_edge; otherwise it increments on each sclk_fall and saturates at SLOT_WIDTH-1.
  - Clock stage guarantees that lrck transitions coincide with sclk falls.
  - On each sclk_fall (including the one coincident with lrck_edge) sdata_out is updated as follows:
    - k=0 (the coincident fall): 0.
    - k=1..DATA_WIDTH: current channel bit DATA_WIDTH-k, MSB first.
    - Otherwise: 0.
  - sdata_out changes 1 mclk after sclk_in falls. It is stable at the following sclk rise because the sclk period is >= 4 mclk.
- Reset mid-frame: everything returns to reset values immediately (asynchronous). Output resumes only after the next lrck_fall, from IDLE.
- No sign extension or truncation; samples are transmitted verbatim.

Optional Feature:
- Macro: I2S_TX_REPEAT_ON_UNDERRUN_EN.
- Defined: on underrun the shift registers reload the last successfully transmitted pair instead of zeros; underrun_out still pulses. The last-pair register resets to 0.
- Undefined: underrun transmits zeros and the last-pair register is not built.

Decomposition:
- Package i2s_pkg:
  - state enum {IDLE, LEFT, RIGHT};
  - default constants I2S_DATA_WIDTH=24 and I2S_SLOT_WIDTH=32, shared with the clock stage;
  - the bit-counter width function clog2(SLOT_WIDTH).
- Sub-module i2s_edge_det (registered prev, rise/fall/any outputs, async reset to 0), instantiated for lrck and sclk.

Test Plan:
Bench: DATA_WIDTH=24, SLOT_WIDTH=32, driven by the clock stage with MCLK_DIV_LRCK=256, MCLK_DIV_SCLK=4.
- Reset, then push L=0xA5A5A5, R=0x5A5A5A before the first lrck fall -> sampled on sclk rises:
  - left slot bits 1..24 = A5A5A5 MSB first; bits 0 and 25..31 = 0;
  - right slot = 5A5A5A in the same layout;
  - underrun_out stays 0.
- No valid_in for 3 frames -> sdata_out all 0; underrun_out pulses exactly 3 times, each 1 mclk wide, 1 mclk after the lrck_fall detection.
- Present pairs P1, P2 back-to-back with valid_in held -> P1 accepted; ready_out=0 until the next lrck_fall load; P2 accepted the cycle after ready_out=1; P1 and P2 transmitted in consecutive frames.
- Full-scale L=0x800000, R=0x7FFFFF -> left bit1=1 then 23 zeros; right bit1=0 then 23 ones.
- Assert arstn_in low mid-right-slot for 2 mclk -> sdata_out=0 and ready_out=1 immediately; no output until the next lrck_fall; the following pushed pair is transmitted correctly.
- With I2S_TX_REPEAT_ON_UNDERRUN_EN: send 0x123456/0x654321 then stop -> the next frame repeats 0x123456/0x654321 with an underrun_out pulse. Without the macro, the same stimulus gives a zero frame.
